// File: rtl/psg_bus_sequencer.sv
// psg_bus_sequencer: serialises CPU sound-port accesses onto the YM2149 register
// buses. Each access becomes one bus phase (LATCH, WRITE or READ). The phase is held
// for HOLD_ENA PSG clock enables and is followed by a single inactive GAP cycle.
// After reset a fixed init sequence mutes both chips. Only then is the bus handed
// to the CPU.
module psg_bus_sequencer #(
    parameter int unsigned HOLD_ENA = 2,
    parameter logic [7:0]  INIT_R7  = 8'h3F
) (
    input  logic       MCLK,
    input  logic       RESET_L,
    input  logic       ENA,
    input  logic       CPU_CS,
    input  logic       CPU_WR,
    input  logic       CPU_RD,
    input  logic [1:0] CPU_ADR,
    input  logic [7:0] CPU_DI,
    output logic [7:0] CPU_DO,
    output logic       CPU_WAIT,
    output logic       PSG_CS0,
    output logic       PSG_CS1,
    output logic       PSG_BDIR,
    output logic       PSG_BC1,
    output logic [7:0] PSG_DA,
    input  logic [7:0] PSG0_DI,
    input  logic [7:0] PSG1_DI,
    output logic       INIT_DONE
);

    localparam logic [2:0] ST_INIT  = 3'd0;
    localparam logic [2:0] ST_IDLE  = 3'd1;
    localparam logic [2:0] ST_PHASE = 3'd2;
    localparam logic [2:0] ST_GAP   = 3'd3;
    localparam logic [2:0] ST_DONE  = 3'd4;

    // The phase ends on the ENA that brings the count up to HOLD_ENA.
    localparam logic [3:0] HOLD_LAST = 4'(HOLD_ENA - 1);
    // The init sequence has 16 phases: 2 chips x 4 registers x (latch, write).
    localparam logic [3:0] INIT_LAST = 4'd15;

    logic [2:0] state;
    logic [3:0] phase_cnt;
    logic [3:0] init_idx;
    logic       served;
    logic       cur_chip;
    logic       cur_read;

    logic       cpu_req;
    logic       served_clr;
    logic       served_set;
    logic       phase_end;
    logic       init_launch;
    logic       init_finish;
    logic       null_read;
    logic [3:0] launch_idx;

    // Init step encoding:
    //   idx[3]   selects the chip.
    //   idx[2:1] selects the register offset from r7.
    //   idx[0]   picks latch (0) or data write (1).
    function automatic logic [7:0] init_byte(input logic [3:0] idx);
        logic [1:0] k;
        k = idx[2:1];
        if (!idx[0]) begin
            init_byte = 8'h07 + {6'd0, k};
        end else if (k == 2'd0) begin
            init_byte = INIT_R7;
        end else begin
            init_byte = 8'h00;
        end
    endfunction

    // Request and sequencing decode shared by the registered blocks below.
    always_comb begin
        cpu_req     = CPU_CS & (CPU_WR | CPU_RD) & ~served;
        served_clr  = ~CPU_CS | ~(CPU_WR | CPU_RD);
        served_set  = (state == ST_GAP) & INIT_DONE;
        phase_end   = (state == ST_PHASE) & ENA & (phase_cnt == HOLD_LAST);
        null_read   = (state == ST_IDLE) & cpu_req & ~CPU_WR & ~CPU_ADR[0];
        init_launch = (state == ST_INIT) |
                      ((state == ST_GAP) & ~INIT_DONE & (init_idx != INIT_LAST));
        init_finish = (state == ST_GAP) & ~INIT_DONE & (init_idx == INIT_LAST);
        launch_idx  = (state == ST_INIT) ? init_idx : init_idx + 4'd1;
    end

    assign CPU_WAIT = cpu_req;

    // Sequencer FSM and the registered bus outputs it drives.
    always_ff @(posedge MCLK or negedge RESET_L) begin
        if (!RESET_L) begin
            state     <= ST_INIT;
            phase_cnt <= 4'd0;
            init_idx  <= 4'd0;
            cur_chip  <= 1'b0;
            cur_read  <= 1'b0;
            PSG_CS0   <= 1'b0;
            PSG_CS1   <= 1'b0;
            PSG_BDIR  <= 1'b0;
            PSG_BC1   <= 1'b0;
            PSG_DA    <= 8'h00;
            INIT_DONE <= 1'b0;
        end else begin
            case (state)
                ST_INIT, ST_GAP: begin
                    if (init_launch) begin
                        // The next init phase follows the gap directly, so the
                        // gap stays exactly one cycle long.
                        init_idx  <= launch_idx;
                        cur_chip  <= launch_idx[3];
                        cur_read  <= 1'b0;
                        phase_cnt <= 4'd0;
                        PSG_CS0   <= ~launch_idx[3];
                        PSG_CS1   <= launch_idx[3];
                        PSG_BDIR  <= 1'b1;
                        PSG_BC1   <= ~launch_idx[0];
                        PSG_DA    <= init_byte(launch_idx);
                        state     <= ST_PHASE;
                    end else if (init_finish) begin
                        INIT_DONE <= 1'b1;
                        state     <= ST_IDLE;
                    end else begin
                        state <= ST_DONE;
                    end
                end
                ST_IDLE: begin
                    if (cpu_req) begin
                        cur_chip  <= CPU_ADR[1];
                        phase_cnt <= 4'd0;
                        if (CPU_WR) begin
                            // A write takes priority when both strobes are high.
                            // ADR0 chooses address latch versus data write.
                            cur_read <= 1'b0;
                            PSG_CS0  <= ~CPU_ADR[1];
                            PSG_CS1  <= CPU_ADR[1];
                            PSG_BDIR <= 1'b1;
                            PSG_BC1  <= ~CPU_ADR[0];
                            PSG_DA   <= CPU_DI;
                            state    <= ST_PHASE;
                        end else if (CPU_ADR[0]) begin
                            cur_read <= 1'b1;
                            PSG_CS0  <= ~CPU_ADR[1];
                            PSG_CS1  <= CPU_ADR[1];
                            PSG_BDIR <= 1'b0;
                            PSG_BC1  <= 1'b1;
                            state    <= ST_PHASE;
                        end else begin
                            // Reading the address port has no bus cycle. It
                            // only passes through the gap so WAIT spans two cycles.
                            cur_read <= 1'b0;
                            state    <= ST_GAP;
                        end
                    end
                end
                ST_PHASE: begin
                    if (ENA) begin
                        phase_cnt <= phase_cnt + 4'd1;
                        if (phase_end) begin
                            PSG_CS0  <= 1'b0;
                            PSG_CS1  <= 1'b0;
                            PSG_BDIR <= 1'b0;
                            PSG_BC1  <= 1'b0;
                            state    <= ST_GAP;
                        end
                    end
                end
                ST_DONE: begin
                    state <= ST_IDLE;
                end
                default: begin
                    state <= ST_INIT;
                end
            endcase
        end
    end

    // Read data register: loaded at the end of a READ phase, or forced to FF by a
    // read of the address port; otherwise it holds its value.
    always_ff @(posedge MCLK or negedge RESET_L) begin
        if (!RESET_L) begin
            CPU_DO <= 8'hFF;
        end else if (null_read) begin
            CPU_DO <= 8'hFF;
        end else if (phase_end && cur_read) begin
            CPU_DO <= cur_chip ? PSG1_DI : PSG0_DI;
        end
    end

    // The served flag stays set until the CPU drops CS or both strobes, so a
    // held strobe produces only one access.
    always_ff @(posedge MCLK or negedge RESET_L) begin
        if (!RESET_L) begin
            served <= 1'b0;
        end else if (served_clr) begin
            served <= 1'b0;
        end else if (served_set) begin
            served <= 1'b1;
        end
    end

endmodule

// File: tb/tb_psg_bus_sequencer.sv
// Bench for psg_bus_sequencer.
//  - A monitor holds a queue of expected bus phases (chip, type, DA).
//  - On every cycle it checks the bus against the phase rules: ENA counting,
//    a single gap between chained phases, stable signals, and read capture.
//  - Directed stimulus pins WAIT, CPU_DO and INIT_DONE with literal values.
module tb_psg_bus_sequencer;

    localparam int         HOLD = 2;
    localparam logic [7:0] R7   = 8'h3F;

    logic       MCLK;
    logic       RESET_L;
    logic       ENA;
    logic       CPU_CS;
    logic       CPU_WR;
    logic       CPU_RD;
    logic [1:0] CPU_ADR;
    logic [7:0] CPU_DI;
    logic [7:0] CPU_DO;
    logic       CPU_WAIT;
    logic       PSG_CS0;
    logic       PSG_CS1;
    logic       PSG_BDIR;
    logic       PSG_BC1;
    logic [7:0] PSG_DA;
    logic [7:0] PSG0_DI;
    logic [7:0] PSG1_DI;
    logic       INIT_DONE;

    psg_bus_sequencer #(.HOLD_ENA(HOLD), .INIT_R7(R7)) dut (
        .MCLK(MCLK), .RESET_L(RESET_L), .ENA(ENA),
        .CPU_CS(CPU_CS), .CPU_WR(CPU_WR), .CPU_RD(CPU_RD),
        .CPU_ADR(CPU_ADR), .CPU_DI(CPU_DI), .CPU_DO(CPU_DO), .CPU_WAIT(CPU_WAIT),
        .PSG_CS0(PSG_CS0), .PSG_CS1(PSG_CS1), .PSG_BDIR(PSG_BDIR), .PSG_BC1(PSG_BC1),
        .PSG_DA(PSG_DA), .PSG0_DI(PSG0_DI), .PSG1_DI(PSG1_DI), .INIT_DONE(INIT_DONE)
    );

    typedef struct {
        logic       chip;
        logic       bdir;
        logic       bc1;
        logic [7:0] da;
        logic       chained;
        logic       is_read;
        logic [7:0] rdata;
    } phase_t;

    phase_t     exp_q[$];
    phase_t     cur;
    logic [7:0] last_da;
    int         checks;
    int         errors;
    int         phase_starts;
    int         sample_idx;
    int         end_sample;
    int         ena_cnt;
    int         ena_div;
    logic       ena_prev;
    logic       prev_active;
    logic       prev_done;
    logic [11:0] prev_bus;
    logic [7:0] init_tab [8];

    initial MCLK = 1'b0;
    always #5 MCLK = ~MCLK;

    // ENA is one MCLK wide, on every 8th clock, and changes 2 time units after the edge.
    initial begin
        ENA = 1'b0;
        ena_div = 0;
        forever begin
            @(posedge MCLK);
            #2;
            ena_div = ena_div + 1;
            ENA = (ena_div % 8 == 0);
        end
    end

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: actual=%0h required=%0h", nm, act, exp);
        end
    endtask

    function automatic void push(input logic chip, input logic bdir, input logic bc1,
                                 input logic [7:0] da, input logic chained,
                                 input logic [7:0] rdata);
        phase_t p;
        p.chip    = chip;
        p.bdir    = bdir;
        p.bc1     = bc1;
        p.da      = bdir ? da : last_da;
        p.chained = chained;
        p.is_read = ~bdir;
        p.rdata   = rdata;
        if (bdir) last_da = da;
        exp_q.push_back(p);
    endfunction

    function automatic void push_init();
        for (int c = 0; c < 2; c++) begin
            for (int i = 0; i < 8; i++) begin
                push(c[0], 1'b1, (i % 2 == 0), init_tab[i], !(c == 0 && i == 0), 8'h00);
            end
        end
    endfunction

    // Monitor: checks the bus against the expected phase queue and the ENA-count rule.
    initial begin
        sample_idx  = 0;
        end_sample  = -100;
        ena_cnt     = 0;
        ena_prev    = 1'b0;
        prev_active = 1'b0;
        prev_done   = 1'b0;
        prev_bus    = '0;
        forever begin
            logic        active;
            logic [11:0] bus;
            @(negedge MCLK);
            sample_idx++;
            bus = {PSG_CS1, PSG_CS0, PSG_BDIR, PSG_BC1, PSG_DA};
            if (!RESET_L) begin
                check("rst_bus", bus, 12'h000);
                check("rst_do", CPU_DO, 8'hFF);
                check("rst_done", INIT_DONE, 1'b0);
                prev_active = 1'b0;
                prev_done   = 1'b0;
            end else begin
                active = PSG_CS0 | PSG_CS1;
                check("cs_excl", PSG_CS0 & PSG_CS1, 1'b0);
                if (!active) check("idle_ctl", {PSG_BDIR, PSG_BC1}, 2'b00);
                if (prev_active) begin
                    if (ena_prev) ena_cnt++;
                    check("phase_len", active, ena_cnt < HOLD);
                    if (active) begin
                        check("phase_stable", bus, prev_bus);
                    end else begin
                        check("gap_da", PSG_DA, prev_bus[7:0]);
                        if (cur.is_read) check("read_do", CPU_DO, cur.rdata);
                        end_sample = sample_idx;
                    end
                end else if (active) begin
                    phase_starts++;
                    ena_cnt = 0;
                    check("phase_expected", exp_q.size() != 0, 1'b1);
                    if (exp_q.size() != 0) begin
                        cur = exp_q.pop_front();
                        check("phase_bus", bus, {cur.chip, ~cur.chip, cur.bdir, cur.bc1, cur.da});
                        if (cur.chained) check("gap_len", sample_idx - end_sample, 1);
                    end
                end
                if (INIT_DONE && !prev_done) check("done_rise", sample_idx - end_sample, 1);
                prev_done   = INIT_DONE;
                prev_active = active;
                prev_bus    = bus;
            end
            ena_prev = ENA;
        end
    end

    task automatic wait_active(input string nm, input int bound);
        int n = 0;
        while (!(PSG_CS0 | PSG_CS1) && n < bound) begin
            @(negedge MCLK);
            n++;
        end
        check(nm, PSG_CS0 | PSG_CS1, 1'b1);
    endtask

    task automatic wait_inactive(input string nm, input int bound);
        int n = 0;
        while ((PSG_CS0 | PSG_CS1) && n < bound) begin
            @(negedge MCLK);
            n++;
        end
        check(nm, PSG_CS0 | PSG_CS1, 1'b0);
    endtask

    task automatic wait_init(input string nm, input int bound, input logic wait_exp);
        int n = 0;
        int bad = 0;
        while (!INIT_DONE && n < bound) begin
            @(negedge MCLK);
            if (!INIT_DONE && CPU_WAIT !== wait_exp) bad++;
            n++;
        end
        check({nm, "_done"}, INIT_DONE, 1'b1);
        check({nm, "_wait"}, bad, 0);
    endtask

    // Runs one CPU bus phase. While the phase is live it disturbs DI/ADR (these
    // must be ignored), then checks WAIT in the gap cycle and one cycle after.
    task automatic cpu_phase(input string nm);
        wait_active({nm, "_start"}, 60);
        #1;
        CPU_DI  = 8'hAA;
        CPU_ADR = CPU_ADR ^ 2'b10;
        wait_inactive({nm, "_end"}, 40);
        check({nm, "_wait_gap"}, CPU_WAIT, 1'b1);
        @(negedge MCLK);
        check({nm, "_wait_rel"}, CPU_WAIT, 1'b0);
    endtask

    initial begin
        int cnt;
        int starts0;
        checks  = 0;
        errors  = 0;
        phase_starts = 0;
        last_da = 8'h00;
        init_tab = '{8'h07, 8'h3F, 8'h08, 8'h00, 8'h09, 8'h00, 8'h0A, 8'h00};
        RESET_L = 1'b0;
        CPU_CS  = 1'b0;
        CPU_WR  = 1'b0;
        CPU_RD  = 1'b0;
        CPU_ADR = 2'b00;
        CPU_DI  = 8'h00;
        PSG0_DI = 8'h00;
        PSG1_DI = 8'h5C;

        // Reset state.
        repeat (3) @(negedge MCLK);
        check("rst_cs0", PSG_CS0, 1'b0);
        check("rst_cs1", PSG_CS1, 1'b0);
        check("rst_ctl", {PSG_BDIR, PSG_BC1}, 2'b00);
        check("rst_da0", PSG_DA, 8'h00);
        check("rst_cpu_do", CPU_DO, 8'hFF);
        check("rst_init_done", INIT_DONE, 1'b0);
        check("rst_wait_nocs", CPU_WAIT, 1'b0);

        // A write request is held through init. It is served after init completes.
        #1;
        CPU_CS  = 1'b1;
        CPU_WR  = 1'b1;
        CPU_ADR = 2'b10;
        CPU_DI  = 8'h0E;
        #1;
        check("wait_in_rst", CPU_WAIT, 1'b1);
        push_init();
        push(1'b1, 1'b1, 1'b1, 8'h0E, 1'b0, 8'h00);
        RESET_L = 1'b1;
        wait_init("init1", 600, 1'b1);

        // CS1 latch 0E, then CS1 write 55.
        cpu_phase("wr_latch");
        #1;
        CPU_WR = 1'b0;
        @(negedge MCLK);
        #1;
        CPU_ADR = 2'b11;
        CPU_DI  = 8'h55;
        CPU_WR  = 1'b1;
        push(1'b1, 1'b1, 1'b0, 8'h55, 1'b0, 8'h00);
        cpu_phase("wr_data");
        #1;
        CPU_WR = 1'b0;

        // Read PSG0 data port.
        @(negedge MCLK);
        #1;
        PSG0_DI = 8'hA7;
        CPU_ADR = 2'b01;
        CPU_RD  = 1'b1;
        push(1'b0, 1'b0, 1'b1, 8'h00, 1'b0, 8'hA7);
        cpu_phase("rd_data");
        check("rd_do", CPU_DO, 8'hA7);
        #1;
        CPU_RD  = 1'b0;
        PSG0_DI = 8'h00;
        repeat (4) @(negedge MCLK);
        check("rd_do_hold", CPU_DO, 8'hA7);

        // Reading the address port: no bus cycle, DO = FF, WAIT for 2 cycles.
        #1;
        CPU_ADR = 2'b00;
        CPU_RD  = 1'b1;
        #1;
        cnt = CPU_WAIT ? 1 : 0;
        repeat (5) begin
            @(negedge MCLK);
            if (CPU_WAIT) cnt++;
        end
        check("nullrd_wait_cycles", cnt, 2);
        check("nullrd_do", CPU_DO, 8'hFF);
        check("nullrd_nobus", PSG_CS0 | PSG_CS1, 1'b0);
        #1;
        CPU_RD = 1'b0;

        // WR held for 100 cycles gives one phase. Re-asserting CS gives another.
        @(negedge MCLK);
        #1;
        starts0 = phase_starts;
        CPU_ADR = 2'b00;
        CPU_DI  = 8'h09;
        CPU_WR  = 1'b1;
        push(1'b0, 1'b1, 1'b1, 8'h09, 1'b0, 8'h00);
        repeat (100) @(negedge MCLK);
        check("hold_one_phase", phase_starts - starts0, 1);
        check("hold_q_empty", exp_q.size(), 0);
        check("hold_wait_low", CPU_WAIT, 1'b0);
        #1;
        CPU_CS = 1'b0;
        @(negedge MCLK);
        #1;
        CPU_CS = 1'b1;
        CPU_ADR = 2'b00;
        CPU_DI  = 8'h09;
        push(1'b0, 1'b1, 1'b1, 8'h09, 1'b0, 8'h00);
        cpu_phase("hold_second");
        check("hold_two_phases", phase_starts - starts0, 2);
        #1;
        CPU_WR = 1'b0;

        // Assert reset in the middle of a PSG0 write phase.
        @(negedge MCLK);
        #1;
        CPU_ADR = 2'b01;
        CPU_DI  = 8'h3C;
        CPU_WR  = 1'b1;
        push(1'b0, 1'b1, 1'b0, 8'h3C, 1'b0, 8'h00);
        wait_active("rw_start", 60);
        repeat (3) @(negedge MCLK);
        check("rw_active", {PSG_CS0, PSG_BDIR, PSG_BC1}, 3'b110);
        #1;
        RESET_L = 1'b0;
        #1;
        check("rw_rst_bus", {PSG_CS0, PSG_CS1, PSG_BDIR, PSG_BC1}, 4'b0000);
        check("rw_rst_done", INIT_DONE, 1'b0);
        CPU_CS = 1'b0;
        CPU_WR = 1'b0;
        repeat (3) @(negedge MCLK);
        #1;
        push_init();
        RESET_L = 1'b1;
        wait_active("init2_start", 10);
        check("init2_first_da", PSG_DA, 8'h07);
        check("init2_first_cs", {PSG_CS1, PSG_CS0, PSG_BDIR, PSG_BC1}, 4'b0111);
        wait_init("init2", 600, 1'b0);
        repeat (5) @(negedge MCLK);
        check("end_q_empty", exp_q.size(), 0);
        check("end_cpu_do", CPU_DO, 8'hFF);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/psg_bus_sequencer.md
Name: psg_bus_sequencer

Overview:
- Sits between the main CPU sound-port decode and the two YM2149 register buses.
- Serialises every CPU access into a timed address-latch, data-write or read bus phase, paced by the shared PSG clock enable, and stalls the CPU with WAIT until the phase completes.
- After reset it runs a built-in init sequence that mutes both chips before granting the bus to the CPU.

Parameters:
- HOLD_ENA, 2, number of ENA pulses each bus phase is held active (1..15).
- INIT_R7, 8'h3F, value written to register 7 (mixer/IO direction) of both chips during init.

Ports:
- MCLK  in  1  system clock.
- RESET_L  in  1  asynchronous active-low reset.
- ENA  in  1  PSG clock enable, one MCLK wide.
- CPU_CS  in  1  sound-port chip select.
- CPU_WR  in  1  write strobe, level.
- CPU_RD  in  1  read strobe, level.
- CPU_ADR  in  2  bit1 = chip (0 = PSG0, 1 = PSG1); bit0 = 0 address latch, 1 data.
- CPU_DI  in  8  CPU write data.
- CPU_DO  out  8  read data, held until the next completed read.
- CPU_WAIT  out  1  stall request, combinational.
- PSG_CS0  out  1  PSG0 bus select.
- PSG_CS1  out  1  PSG1 bus select.
- PSG_BDIR  out  1  bus direction.
- PSG_BC1  out  1  bus control 1.
- PSG_DA  out  8  data/address to both chips.
- PSG0_DI  in  8  PSG0 read data.
- PSG1_DI  in  8  PSG1 read data.
- INIT_DONE  out  1  high once the init sequence completes.

Behaviour:
- Reset values, while RESET_L is low or after its deassertion:
  - PSG_CS0 = PSG_CS1 = PSG_BDIR = PSG_BC1 = 0.
  - PSG_DA = 0, CPU_DO = 8'hFF, INIT_DONE = 0.
  - Served flag = 0; phase counter = 0; state = INIT.
- Bus phase encodings:
  - LATCH: BDIR=1, BC1=1.
  - WRITE: BDIR=1, BC1=0.
  - READ: BDIR=0, BC1=1.
  - INACTIVE: BDIR=0, BC1=0.
  - Exactly one of CS0/CS1 is high during a phase; both are low otherwise.
  - All bus outputs are registered.
- Phase timing:
  - On phase entry the counter is cleared.
  - The counter increments on each ENA.
  - The phase ends on the MCLK edge where the HOLD_ENA-th ENA is counted.
  - It is followed by exactly one GAP cycle with the bus INACTIVE and DA unchanged.
  - An ENA coincident with the entry edge is not counted.
- Init sequence, fixed order, each entry = LATCH(reg) + GAP + WRITE(val) + GAP:
  - PSG0 r7 = INIT_R7; PSG0 r8/r9/r10 = 0.
  - Then the same four writes for PSG1.
  - Total 16 phases.
  - INIT_DONE rises on the cycle after the final GAP and stays high until reset.
- CPU_WAIT = CPU_CS & (CPU_WR | CPU_RD) & ~served.
  - It stays high throughout init and throughout any pending phase.
- States: INIT, IDLE, PHASE, GAP, DONE.
- IDLE, on a request (CS & (WR|RD) & ~served):
  - WR=1 (WR wins if both strobes are high):
    - ADR0=0 → LATCH with DA=CPU_DI.
    - ADR0=1 → WRITE with DA=CPU_DI.
  - RD=1, ADR0=1 → READ; DA unchanged.
  - RD=1, ADR0=0 → no bus cycle; CPU_DO=8'hFF; served set next cycle.
  - Chip is selected by ADR1.
  - The bus phase is visible on the MCLK edge after the request is sampled (1-cycle latency).
- READ captures PSG0_DI or PSG1_DI (per selected chip) into CPU_DO on the phase-ending edge.
- DONE: served set for one cycle while returning to IDLE.
- The served flag clears when CPU_CS = 0 or both strobes are 0.
  - A held strobe therefore produces exactly one bus access.
- CPU inputs are sampled only in IDLE.
  - Changes to CPU_DI or CPU_ADR during a phase have no effect.
- Asynchronous reset mid-phase:
  - Drops the bus INACTIVE immediately.
  - Init restarts from PSG0 r7 after RESET_L deasserts.

Test Plan:
- Reset release, ENA every 8 MCLK, HOLD_ENA=2:
  - Observe 16 phases: DA sequence 07,3F,08,00,09,00,0A,00 with CS0, then the same with CS1.
  - Each phase lasts 16±1 MCLK; INIT_DONE=1 after the last GAP; CPU_WAIT high throughout if CS asserted.
- CPU write ADR=2'b10 DI=8'h0E, then ADR=2'b11 DI=8'h55:
  - Bus shows CS1 LATCH DA=0E, GAP, CS1 WRITE DA=55.
  - CPU_WAIT drops the cycle after each phase's GAP; CS0 stays 0.
- CPU read ADR=2'b01 with PSG0_DI=8'hA7:
  - READ phase on CS0; CPU_DO=A7 after the phase; WAIT released.
  - Changing PSG0_DI to 00 afterwards leaves CPU_DO=A7.
- CPU read ADR=2'b00:
  - No bus activity; CPU_DO=FF; WAIT high for exactly 2 cycles.
- CPU holds WR for 100 cycles on one access:
  - Exactly one bus phase occurs.
  - After CS drops and reasserts, a second phase occurs.
- RESET_L pulsed low during a CPU WRITE phase:
  - Bus goes INACTIVE the same cycle; INIT_DONE=0.
  - Init restarts with DA=07 on CS0.
